regfile: RTL and testbench
==========================

# regfile

Parametrised general-purpose register file, successor to the fixed two-register set. It holds `DEPTH` registers of `WIDTH` bits, each writable from the data path and each able to increment or decrement in place for pointer/counter use. It provides one tristated bus read port and one ALU read port, and registered carry/zero flags from the last modify operation. It sits between the main bus and the ALU operand mux.

## Interface
Parameters:
- `WIDTH`, 16: register width in bits; must be ≥ 2.
- `DEPTH`, 4: number of registers; must be a power of two and ≥ 2.
- `SEL_W` is derived as `$clog2(DEPTH)`; it is not overridable.

Ports:
- `i_clk` in 1: the single clock; all state updates on its rising edge.
- `i_nReset` in 1: asynchronous, active-low reset.
- `i_d` in `WIDTH`: write data.
- `i_wSel` in `SEL_W`: target register for write/inc/dec.
- `i_write` in 1: load `i_d` into `r[i_wSel]`.
- `i_inc` in 1: `r[i_wSel] <= r[i_wSel] + 1`.
- `i_dec` in 1: `r[i_wSel] <= r[i_wSel] - 1`.
- `i_busSel` in `SEL_W`: register driven onto the bus.
- `i_nBusEn` in 1: active-low bus output enable.
- `o_bus` out `WIDTH`: tristate; carries `r[i_busSel]` when `i_nBusEn`=0, otherwise all `Z`.
- `i_aluSel` in `SEL_W`: register presented to the ALU.
- `o_alu` out `WIDTH`: `r[i_aluSel]`; always driven.
- `o_carry` out 1: registered wrap flag.
- `o_zero` out 1: registered zero flag.

## Operation
- Operation priority on a clock edge, with one op per edge on `r[i_wSel]`:
  - `i_write`=1: load `i_d`. `i_inc` and `i_dec` are ignored.
  - Else `i_inc`=1 and `i_dec`=1 together: no change to the register or the flags.
  - Else `i_inc`=1: add 1, modulo 2^`WIDTH`.
  - Else `i_dec`=1: subtract 1, modulo 2^`WIDTH`.
  - None asserted: every register and both flags hold.
- Flags update only on an edge where an op takes effect.
  - `o_carry`: 1 if inc wrapped all-ones→0 or dec wrapped 0→all-ones; 0 for a non-wrapping inc/dec; 0 on a write.
  - `o_zero`: 1 if the new value of the target register is 0 (this applies to writes, incs and decs).
- Registers other than `r[i_wSel]` never change on an op.
- Read ports are combinational from register state. Bus and ALU may select the same or different registers simultaneously.
- Reset (`i_nReset`=0, at any time including mid-operation):
  - Every register is forced to all-ones.
  - `o_carry`=0 and `o_zero`=0.
  - Ops are ignored while reset is held.
  - `o_bus` still follows `i_nBusEn`, so after reset it shows all-ones when enabled.

## Timing
- Write/inc/dec latency is 1 cycle: the new value is readable on `o_bus`/`o_alu` after the rising edge.
- The flags are valid in the same cycle as the new register value.
- Read path is zero-latency combinational: sel → data.
- `o_bus` goes to high-Z combinationally when `i_nBusEn` rises; there is no clocked turn-off.
- Reset assertion is asynchronous and immediate. Deassertion is expected synchronised upstream; the first op is accepted on the first rising edge with `i_nReset`=1.
- Inputs must be stable around the `i_clk` rising edge; there is no internal input registering.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Both read ports forward combinationally.
  - If `i_aluSel`==`i_wSel` (respectively `i_busSel`==`i_wSel`, bus enabled) and an op takes effect this cycle, the port shows the post-op value before the edge.
  - Flags are unaffected (still registered).
- Not defined: read ports always show the current stored value; the new value appears only after the edge.

## Test plan
- Reset: pulse `i_nReset` low mid-cycle.
  - Every register reads 0xFFFF via `o_alu` for sel 0..3.
  - `o_carry`=0, `o_zero`=0.
  - `o_bus`=Z with `i_nBusEn`=1, and 0xFFFF with `i_nBusEn`=0 and `i_busSel`=2.
- Write then read: write 0x1234 to r3 and 0xABCD to r1.
  - Next cycle `i_aluSel`=3 gives 0x1234 and `i_busSel`=1 gives bus 0xABCD, in the same cycle.
  - r0 and r2 remain 0xFFFF; `o_zero`=0, `o_carry`=0.
- Wrap: after reset, inc r0.
  - r0=0x0000, `o_carry`=1, `o_zero`=1.
  - Then dec r0: r0=0xFFFF, `o_carry`=1, `o_zero`=0.
  - Then dec r0 again: r0=0xFFFE, `o_carry`=0.
- Priority:
  - `i_write`=1 with `i_inc`=1, `i_d`=0x0010, target r2: r2=0x0010, `o_carry`=0.
  - `i_inc`=`i_dec`=1 on r2: r2 stays 0x0010 and flags hold.
- Reset mid-sequence: assert `i_nReset` during a run of incs on r1 that has reached 0x0005.
  - r1 reads 0xFFFF immediately, before the next edge.
  - Incs while reset is held have no effect.
- Bypass (`REGFILE_BYPASS_EN`): write 0x5555 to r0 with `i_aluSel`=0.
  - `o_alu`=0x5555 in the same cycle.
  - Without the macro: `o_alu`=0xFFFF until the edge, then 0x5555.

Source files
------------

// File: rtl/regfile.sv
// regfile: DEPTH x WIDTH registers with write/inc/dec, a tristate bus read port, an ALU read port and carry/zero flags.
// Latency: ops land on the rising edge; reads are combinational (REGFILE_BYPASS_EN forwards the pending op).
// Backpressure: none; one op per edge on r[i_wSel], always accepted while out of reset.
module regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_nReset,
  input  logic [WIDTH-1:0] i_d,
  input  logic [SEL_W-1:0] i_wSel,
  input  logic             i_write,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [SEL_W-1:0] i_busSel,
  input  logic             i_nBusEn,
  output logic [WIDTH-1:0] o_bus,
  input  logic [SEL_W-1:0] i_aluSel,
  output logic [WIDTH-1:0] o_alu,
  output logic             o_carry,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] nxt_val;
  logic             op_en;
  logic             wrap;
  logic [WIDTH-1:0] bus_val;
  logic [WIDTH-1:0] alu_val;

  assign cur_val = regs[i_wSel];

  // inc together with dec cancels out: no register or flag update
  always_comb begin
    op_en   = 1'b0;
    nxt_val = cur_val;
    wrap    = 1'b0;
    if (i_nReset) begin
      if (i_write) begin
        op_en   = 1'b1;
        nxt_val = i_d;
      end else if (i_inc && !i_dec) begin
        op_en   = 1'b1;
        nxt_val = cur_val + ONE;
        wrap    = &cur_val;
      end else if (i_dec && !i_inc) begin
        op_en   = 1'b1;
        nxt_val = cur_val - ONE;
        wrap    = (cur_val == '0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '1;
      end
      o_carry <= 1'b0;
      o_zero  <= 1'b0;
    end else if (op_en) begin
      regs[i_wSel] <= nxt_val;
      o_carry      <= wrap;
      o_zero       <= (nxt_val == '0);
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign alu_val = (op_en && (i_aluSel == i_wSel)) ? nxt_val : regs[i_aluSel];
  assign bus_val = (op_en && (i_busSel == i_wSel)) ? nxt_val : regs[i_busSel];
`else
  assign alu_val = regs[i_aluSel];
  assign bus_val = regs[i_busSel];
`endif

  assign o_alu = alu_val;
  assign o_bus = i_nBusEn ? {WIDTH{1'bz}} : bus_val;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, wrap flags, op priority, async reset mid-run, read forwarding.
module tb_regfile;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] d;
  logic [1:0]  w_sel;
  logic        write, inc, dec;
  logic [1:0]  bus_sel;
  logic        n_bus_en;
  wire  [15:0] bus;
  logic [1:0]  alu_sel;
  logic [15:0] alu;
  logic        carry, zero;

  int checks = 0;
  int errors = 0;

  regfile #(.WIDTH(16), .DEPTH(4)) dut (
    .i_clk    (clk),
    .i_nReset (n_reset),
    .i_d      (d),
    .i_wSel   (w_sel),
    .i_write  (write),
    .i_inc    (inc),
    .i_dec    (dec),
    .i_busSel (bus_sel),
    .i_nBusEn (n_bus_en),
    .o_bus    (bus),
    .i_aluSel (alu_sel),
    .o_alu    (alu),
    .o_carry  (carry),
    .o_zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // a released bus is Z on a 4-state simulator and resolves to 0 on a 2-state one
  task automatic check_bus_off(input string tag);
    checks++;
    assert ((bus === 16'hzzzz) || (bus === 16'h0000)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=zzzz", tag, bus);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #3 n_reset = 1'b0;
    #2 n_reset = 1'b1;
  endtask

  initial begin
    n_reset = 1'b1; d = '0; w_sel = '0; write = 0; inc = 0; dec = 0;
    bus_sel = '0; n_bus_en = 1'b1; alu_sel = '0;

    // reset pulsed mid-cycle
    tick();
    #3 n_reset = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) begin
      alu_sel = 2'(s);
      #1 check($sformatf("rst_r%0d", s), alu, 16'hFFFF);
    end
    check("rst_carry", {15'd0, carry}, 16'd0);
    check("rst_zero",  {15'd0, zero},  16'd0);
    check_bus_off("rst_bus_off");
    n_bus_en = 1'b0; bus_sel = 2'd2;
    #1 check("rst_bus_r2", bus, 16'hFFFF);
    n_reset = 1'b1; n_bus_en = 1'b1;

    // write r3 and r1, read both ports together
    tick();
    write = 1; w_sel = 2'd3; d = 16'h1234;
    tick();
    w_sel = 2'd1; d = 16'hABCD;
    tick();
    write = 0;
    alu_sel = 2'd3; bus_sel = 2'd1; n_bus_en = 1'b0;
    #1;
    check("wr_alu_r3", alu, 16'h1234);
    check("wr_bus_r1", bus, 16'hABCD);
    alu_sel = 2'd0; #1 check("wr_r0_hold", alu, 16'hFFFF);
    alu_sel = 2'd2; #1 check("wr_r2_hold", alu, 16'hFFFF);
    check("wr_zero",  {15'd0, zero},  16'd0);
    check("wr_carry", {15'd0, carry}, 16'd0);
    n_bus_en = 1'b1;

    // wrap in both directions on r0
    reset_pulse();
    tick();
    alu_sel = 2'd0; w_sel = 2'd0; inc = 1;
    tick();
    inc = 0;
    check("inc_wrap_r0", alu, 16'h0000);
    check("inc_wrap_carry", {15'd0, carry}, 16'd1);
    check("inc_wrap_zero",  {15'd0, zero},  16'd1);
    dec = 1;
    tick();
    check("dec_wrap_r0", alu, 16'hFFFF);
    check("dec_wrap_carry", {15'd0, carry}, 16'd1);
    check("dec_wrap_zero",  {15'd0, zero},  16'd0);
    tick();
    dec = 0;
    check("dec_r0", alu, 16'hFFFE);
    check("dec_carry", {15'd0, carry}, 16'd0);

    // write beats inc
    write = 1; inc = 1; d = 16'h0010; w_sel = 2'd2;
    tick();
    write = 0; inc = 0;
    alu_sel = 2'd2;
    #1 check("prio_wr_r2", alu, 16'h0010);
    check("prio_wr_carry", {15'd0, carry}, 16'd0);
    // set both flags via r3 wrap, then inc+dec on r2 must leave them
    w_sel = 2'd3; inc = 1;
    tick();
    inc = 0;
    check("r3_wrap_carry", {15'd0, carry}, 16'd1);
    w_sel = 2'd2; inc = 1; dec = 1;
    tick();
    inc = 0; dec = 0;
    check("incdec_r2", alu, 16'h0010);
    check("incdec_carry", {15'd0, carry}, 16'd1);
    check("incdec_zero",  {15'd0, zero},  16'd1);
    tick();
    alu_sel = 2'd3;
    #1 check("idle_r3", alu, 16'h0000);
    check("idle_carry", {15'd0, carry}, 16'd1);

    // async reset during a run of incs on r1
    write = 1; w_sel = 2'd1; d = 16'h0000;
    tick();
    write = 0; inc = 1; alu_sel = 2'd1;
    repeat (5) tick();
    check("run_r1_5", alu, 16'h0005);
    #3 n_reset = 1'b0;
    #1 check("async_rst_r1", alu, 16'hFFFF);
    tick();
    tick();
    check("rst_held_r1", alu, 16'hFFFF);
    check("rst_held_carry", {15'd0, carry}, 16'd0);
    #3 n_reset = 1'b1;
    tick();
    inc = 0;
    check("post_rst_inc_r1", alu, 16'h0000);
    check("post_rst_carry", {15'd0, carry}, 16'd1);
    check("post_rst_zero",  {15'd0, zero},  16'd1);

    // read forwarding of a pending write to r0 (r0 is 0xFFFF here)
    write = 1; w_sel = 2'd0; d = 16'h5555; alu_sel = 2'd0; bus_sel = 2'd0; n_bus_en = 1'b0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_alu_pre", alu, 16'h5555);
    check("byp_bus_pre", bus, 16'h5555);
`else
    check("byp_alu_pre", alu, 16'hFFFF);
    check("byp_bus_pre", bus, 16'hFFFF);
`endif
    tick();
    write = 0;
    check("byp_alu_post", alu, 16'h5555);
    check("byp_bus_post", bus, 16'h5555);
    n_bus_en = 1'b1;
    #1 check_bus_off("bus_off_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
